vga_timing_scaled_gen: RTL and testbench

Parametrised successor to the fixed 800x600@60, 4x4-downscaled VGA top. It generates programmable H/V timing with selectable sync polarity, a power-of-two downscale factor and configurable colour depth. Each active pixel issues a downscaled framebuffer coordinate, and hsync/vsync/blanking are delayed to match a framebuffer read latency. It sits between the pixel-clock domain logic (framebuffer or RAM) and the VGA pins.

---
 rtl/vga_timing_scaled_gen_pkg.sv | 46 ++++
 rtl/vga_ce_delay.sv | 37 +++
 rtl/vga_timing_scaled_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_scaled_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_scaled_gen_pkg.sv
// Mode constants, shared types and width helper for the scaled VGA timing generator.
package vga_timing_scaled_gen_pkg;

    // 800x600@60, 40 MHz pixel clock, positive syncs
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;
    localparam bit VGA800_H_SYNC_POL = 1'b1;
    localparam bit VGA800_V_SYNC_POL = 1'b1;

    // 640x480@60, 25.175 MHz pixel clock, negative syncs
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_H_SYNC_POL = 1'b0;
    localparam bit VGA640_V_SYNC_POL = 1'b0;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } line_flags_t;

    // Bits needed to index 0..value-1, never less than one.
    function automatic int vga_clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_ce_delay.sv
// Clock-enable qualified shift register; DEPTH=0 degenerates to a wire.
// Entries reset to zero, which callers use as the idle/inactive encoding.
module vga_ce_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, reset, ce};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stages[i] <= '0;
                end
            end else if (ce) begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_scaled_gen.sv
// Programmable VGA timing with power-of-two downscaled framebuffer addressing.
// Addresses are combinational from the counters; syncs and colour reach the pins RD_LATENCY+1 ticks later.
module vga_timing_scaled_gen
    import vga_timing_scaled_gen_pkg::*;
#(
    parameter int H_ACTIVE   = VGA800_H_ACTIVE,
    parameter int H_FP       = VGA800_H_FP,
    parameter int H_SYNC     = VGA800_H_SYNC,
    parameter int H_BP       = VGA800_H_BP,
    parameter int V_ACTIVE   = VGA800_V_ACTIVE,
    parameter int V_FP       = VGA800_V_FP,
    parameter int V_SYNC     = VGA800_V_SYNC,
    parameter int V_BP       = VGA800_V_BP,
    parameter bit H_SYNC_POL = VGA800_H_SYNC_POL,
    parameter bit V_SYNC_POL = VGA800_V_SYNC_POL,
    parameter int SCALE_LOG2 = 2,
    parameter int COLOR_BITS = 2,
    parameter int RD_LATENCY = 2,
    parameter int XW         = vga_clog2(H_ACTIVE >> SCALE_LOG2),
    parameter int YW         = vga_clog2(V_ACTIVE >> SCALE_LOG2)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_pix_ce,
    input  logic [3*COLOR_BITS-1:0] i_rgb,
    output logic [XW-1:0]           o_x,
    output logic [YW-1:0]           o_y,
    output logic                    o_addr_valid,
    output logic                    o_frame_start,
    output logic                    o_line_start,
    output logic [COLOR_BITS-1:0]   o_red,
    output logic [COLOR_BITS-1:0]   o_green,
    output logic [COLOR_BITS-1:0]   o_blue,
    output logic                    o_hsync,
    output logic                    o_vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = vga_clog2(H_TOTAL);
    localparam int VCW     = vga_clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FP + V_SYNC);

    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 4) begin : g_bad_scale_range
        $error("SCALE_LOG2 must be in 0..4");
    end
    if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0 || (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_bad_scale
        $error("H_ACTIVE and V_ACTIVE must be multiples of 2**SCALE_LOG2");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("porch and sync widths must be non-zero");
    end
    if (RD_LATENCY < 0 || RD_LATENCY > 8) begin : g_bad_latency
        $error("RD_LATENCY must be in 0..8");
    end

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    line_flags_t    addr_flags;
    line_flags_t    dly_flags;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        addr_flags.active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        addr_flags.hsync  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        addr_flags.vsync  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    end

    assign o_addr_valid = addr_flags.active;
    assign o_x          = addr_flags.active ? XW'(h_cnt >> SCALE_LOG2) : '0;
    assign o_y          = addr_flags.active ? YW'(v_cnt >> SCALE_LOG2) : '0;

    // Gated by reset so the pulses cannot linger while the counters are held at zero.
    assign o_line_start  = i_pix_ce && !i_reset && (h_cnt == '0);
    assign o_frame_start = o_line_start && (v_cnt == '0);

    vga_ce_delay #(
        .WIDTH ($bits(line_flags_t)),
        .DEPTH (RD_LATENCY)
    ) u_flag_delay (
        .clk   (i_clk),
        .reset (i_reset),
        .ce    (i_pix_ce),
        .d     (addr_flags),
        .q     (dly_flags)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
            o_hsync <= ~H_SYNC_POL;
            o_vsync <= ~V_SYNC_POL;
        end else if (i_pix_ce) begin
            o_red   <= dly_flags.active ? i_rgb[3*COLOR_BITS-1 -: COLOR_BITS] : '0;
            o_green <= dly_flags.active ? i_rgb[2*COLOR_BITS-1 -: COLOR_BITS] : '0;
            o_blue  <= dly_flags.active ? i_rgb[COLOR_BITS-1 -: COLOR_BITS] : '0;
            o_hsync <= dly_flags.hsync ? H_SYNC_POL : ~H_SYNC_POL;
            o_vsync <= dly_flags.vsync ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_scaled_gen.sv
// Bench: a small 16x8 mode (scale 4, latency 2) plus the 640x480 mode (scale 1, latency 0).
module tb_vga_timing_scaled_gen;
    import vga_timing_scaled_gen_pkg::*;

    // small mode for instance A: 23 pixels x 12 lines
    localparam int AH = 16, AHF = 2, AHS = 3, AHB = 2;
    localparam int AV = 8,  AVF = 1, AVS = 2, AVB = 1;
    localparam int AHT = AH + AHF + AHS + AHB;
    localparam int AVT = AV + AVF + AVS + AVB;

    logic clk;
    logic rst_a, rst_b, ce_a, ce_b;
    logic [5:0] rgb_a, rgb_b;
    logic [1:0] x_a;
    logic       y_a;
    logic       av_a, fs_a, ls_a, hs_a, vs_a;
    logic [1:0] r_a, g_a, b_a;
    logic [9:0] x_b;
    logic [8:0] y_b;
    logic       av_b, fs_b, ls_b, hs_b, vs_b;
    logic [1:0] r_b, g_b, b_b;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_scaled_gen #(
        .H_ACTIVE(AH), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
        .V_ACTIVE(AV), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .SCALE_LOG2(2), .COLOR_BITS(2), .RD_LATENCY(2)
    ) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_pix_ce(ce_a), .i_rgb(rgb_a),
        .o_x(x_a), .o_y(y_a), .o_addr_valid(av_a),
        .o_frame_start(fs_a), .o_line_start(ls_a),
        .o_red(r_a), .o_green(g_a), .o_blue(b_a),
        .o_hsync(hs_a), .o_vsync(vs_a)
    );

    vga_timing_scaled_gen #(
        .H_ACTIVE(VGA640_H_ACTIVE), .H_FP(VGA640_H_FP), .H_SYNC(VGA640_H_SYNC), .H_BP(VGA640_H_BP),
        .V_ACTIVE(VGA640_V_ACTIVE), .V_FP(VGA640_V_FP), .V_SYNC(VGA640_V_SYNC), .V_BP(VGA640_V_BP),
        .H_SYNC_POL(VGA640_H_SYNC_POL), .V_SYNC_POL(VGA640_V_SYNC_POL),
        .SCALE_LOG2(0), .COLOR_BITS(2), .RD_LATENCY(0)
    ) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_pix_ce(ce_b), .i_rgb(rgb_b),
        .o_x(x_b), .o_y(y_b), .o_addr_valid(av_b),
        .o_frame_start(fs_b), .o_line_start(ls_b),
        .o_red(r_b), .o_green(g_b), .o_blue(b_b),
        .o_hsync(hs_b), .o_vsync(vs_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Framebuffer models: A answers two pixel ticks after the address, B answers immediately.
    logic [1:0] fb_x [2];
    logic       fb_y [2];
    always @(posedge clk) begin
        if (ce_a) begin
            fb_x[0] <= x_a;
            fb_y[0] <= y_a;
            fb_x[1] <= fb_x[0];
            fb_y[1] <= fb_y[0];
        end
    end
    assign rgb_a = {fb_x[1], 1'b1, fb_y[1], ~fb_x[1]};
    assign rgb_b = {x_b[1:0], y_b[1:0], x_b[3:2]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] pk(input logic [1:0] x, input logic y, input logic av,
                                       input logic fs, input logic ls, input logic hs,
                                       input logic vs, input logic [1:0] r, input logic [1:0] g,
                                       input logic [1:0] b);
        return {x, y, av, fs, ls, hs, vs, r, g, b};
    endfunction

    // Expected A outputs t cycles after release with the pixel tick held high.
    function automatic logic [14:0] model_a(input int t);
        int h, v, n, ho, vo;
        logic av, hs, vs;
        logic [1:0] x, y, r, g, b;
        h = t % AHT;
        v = (t / AHT) % AVT;
        av = (h < AH) && (v < AV);
        x = av ? 2'(h >> 2) : 2'd0;
        y = av ? 2'(v >> 2) : 2'd0;
        hs = 1'b0; vs = 1'b0; r = 2'd0; g = 2'd0; b = 2'd0;
        if (t >= 3) begin
            n = t - 3;
            ho = n % AHT;
            vo = (n / AHT) % AVT;
            hs = (ho >= AH + AHF) && (ho < AH + AHF + AHS);
            vs = (vo >= AV + AVF) && (vo < AV + AVF + AVS);
            if (ho < AH && vo < AV) begin
                r = 2'(ho >> 2);
                g = {1'b1, 1'(vo >> 2)};
                b = ~r;
            end
        end
        return pk(x, y[0], av, (h == 0 && v == 0), (h == 0), hs, vs, r, g, b);
    endfunction

    typedef struct {
        int          t;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs [17];
    logic [14:0] got_a;
    assign got_a = {x_a, y_a, av_a, fs_a, ls_a, hs_a, vs_a, r_a, g_a, b_a};

    initial begin
        int vi;
        int fall1, fall2, rise1, prev_hs_b;
        int k_rise, k_fall, fs_cnt, ls_cnt, prev_hs_a;

        //            t     x  y av fs ls hs vs  r  g  b
        vecs[0]  = '{0,   pk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1,   pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{3,   pk(0, 0, 1, 0, 0, 0, 0, 0, 2, 3)};
        vecs[3]  = '{7,   pk(1, 0, 1, 0, 0, 0, 0, 1, 2, 2)};
        vecs[4]  = '{15,  pk(3, 0, 1, 0, 0, 0, 0, 3, 2, 0)};
        vecs[5]  = '{16,  pk(0, 0, 0, 0, 0, 0, 0, 3, 2, 0)};
        vecs[6]  = '{19,  pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{21,  pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
        vecs[8]  = '{23,  pk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0)};
        vecs[9]  = '{24,  pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{97,  pk(1, 1, 1, 0, 0, 0, 0, 0, 3, 3)};
        vecs[11] = '{184, pk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[12] = '{210, pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[13] = '{255, pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[14] = '{256, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[15] = '{276, pk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0)};
        vecs[16] = '{279, pk(0, 0, 1, 0, 0, 0, 0, 0, 2, 3)};

        rst_a = 1'b1; rst_b = 1'b1; ce_a = 1'b1; ce_b = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;

        vi = 0; fall1 = -1; fall2 = -1; rise1 = -1; prev_hs_b = 1;
        for (int t = 0; t <= 1667; t++) begin
            if (t > 0) begin
                @(negedge clk);
                #1;
            end
            if (vi < 17 && vecs[vi].t == t) begin
                check($sformatf("vec_t%0d", t), 32'(got_a), 32'(vecs[vi].exp));
                vi++;
            end
            check($sformatf("sweep_a_t%0d", t), 32'(got_a), 32'(model_a(t)));
            if (t == 0) begin
                check("b_reset_sync_fs", {29'd0, hs_b, vs_b, fs_b}, 32'b111);
            end
            if (t == 6) begin
                check("b_addr_rgb_t6", {16'd0, x_b, r_b, g_b, b_b}, {16'd0, 10'd6, 6'b01_00_01});
            end
            if (t > 0) begin
                if (prev_hs_b == 1 && hs_b == 1'b0) begin
                    if (fall1 < 0) fall1 = t;
                    else if (fall2 < 0) fall2 = t;
                end
                if (prev_hs_b == 0 && hs_b == 1'b1 && rise1 < 0) rise1 = t;
            end
            prev_hs_b = int'(hs_b);
        end
        check("b_hsync_first_fall", 32'(fall1), 32'd657);
        check("b_hsync_width", 32'(rise1 - fall1), 32'd96);
        check("b_hsync_period", 32'(fall2 - fall1), 32'd800);

        // mid-frame reset: both instances are showing active, non-black pixels here
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        #1;
        check("a_reset_outputs", 32'({x_a, y_a, av_a, hs_a, vs_a, r_a, g_a, b_a}), 32'b00_0_1_0_0_000000);
        check("b_reset_outputs", 32'({hs_b, vs_b, r_b, g_b, b_b, x_b}), {14'd0, 1'b1, 1'b1, 6'd0, 10'd0});
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("a_fs_after_reset", 32'(fs_a), 32'd1);
        check("b_fs_after_reset", 32'(fs_b), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("a_restart_rgb", 32'({r_a, g_a, b_a}), 32'b00_10_11);
        check("b_restart_rgb", 32'({r_b, g_b, b_b}), 32'b10_00_00);

        // pixel tick one clock in four
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0; ce_a = 1'b1;
        #1;
        k_rise = -1; k_fall = -1; fs_cnt = 0; ls_cnt = 0; prev_hs_a = 0;
        for (int k = 0; k <= 120; k++) begin
            if (k > 0) begin
                @(negedge clk);
                ce_a = (k % 4 == 0);
                #1;
            end
            if (k == 0) check("slow_fs_k0", 32'(fs_a), 32'd1);
            if (k == 92) check("slow_ls_k92", 32'(ls_a), 32'd1);
            if (k == 24) check("slow_red_k24", 32'(r_a), 32'd0);
            if (k == 25) check("slow_red_k25", 32'(r_a), 32'd1);
            if (k == 28) check("slow_red_hold_k28", 32'(r_a), 32'd1);
            fs_cnt += int'(fs_a);
            ls_cnt += int'(ls_a);
            if (prev_hs_a == 0 && hs_a == 1'b1 && k_rise < 0) k_rise = k;
            if (prev_hs_a == 1 && hs_a == 1'b0 && k_fall < 0) k_fall = k;
            prev_hs_a = int'(hs_a);
        end
        check("slow_fs_pulses", 32'(fs_cnt), 32'd1);
        check("slow_ls_pulses", 32'(ls_cnt), 32'd2);
        check("slow_hsync_rise", 32'(k_rise), 32'd81);
        check("slow_hsync_width", 32'(k_fall - k_rise), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
